// File: rtl/pipe_reg_chain.sv
// Parametrised chain of pipeline boundary registers with per-stage hold/flush resolution
// and saturating stall/flush performance counters.
module pipe_reg_chain #(
  parameter int               NUM_STAGES = 4,
  parameter int               WIDTH      = 64,
  parameter logic [WIDTH-1:0] NOP_VALUE  = '0,
  parameter int               COUNT_W    = 32
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_STAGES*WIDTH-1:0]      in_data,
  input  logic [NUM_STAGES-1:0]            in_valid,
  input  logic [NUM_STAGES-1:0]            hold_req,
  input  logic [NUM_STAGES-1:0]            flush_req,
  input  logic                             clr_counters,
  output logic [NUM_STAGES*WIDTH-1:0]      out_data,
  output logic [NUM_STAGES-1:0]            out_valid,
  output logic [$clog2(NUM_STAGES+1)-1:0]  valid_count,
  output logic [COUNT_W-1:0]               stall_cycles,
  output logic [COUNT_W-1:0]               flush_events
);

  localparam int VC_W = $clog2(NUM_STAGES+1);

  logic [NUM_STAGES*WIDTH-1:0] data_q, data_d;
  logic [NUM_STAGES-1:0]       valid_q, valid_d;
  logic [NUM_STAGES-1:0]       eff_hold;
  logic [NUM_STAGES-1:0]       younger_held;
  logic [COUNT_W-1:0]          stall_q, flush_q;

  // A hold at boundary j freezes every boundary at or below j.
  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_hold
    assign eff_hold[g] = |(hold_req >> g);
  end

  // Bit i is set when boundary i-1 is held; boundary 0 has nothing younger.
  assign younger_held = {eff_hold[NUM_STAGES-2:0], 1'b0};

  // Priority per boundary: flush, hold, bubble, then normal capture.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (flush_req[i]) begin
        data_d[i*WIDTH +: WIDTH] = NOP_VALUE;
        valid_d[i]               = 1'b0;
      end else if (eff_hold[i]) begin
        data_d[i*WIDTH +: WIDTH] = data_q[i*WIDTH +: WIDTH];
        valid_d[i]               = valid_q[i];
      end else if (younger_held[i]) begin
        data_d[i*WIDTH +: WIDTH] = NOP_VALUE;
        valid_d[i]               = 1'b0;
      end else begin
        data_d[i*WIDTH +: WIDTH] = in_data[i*WIDTH +: WIDTH];
        valid_d[i]               = in_valid[i];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_q  <= {NUM_STAGES{NOP_VALUE}};
      valid_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  // Counters stick at all-ones; clear beats increment.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else if (clr_counters) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (|hold_req && (stall_q != {COUNT_W{1'b1}}))
        stall_q <= stall_q + 1'b1;
      if (|flush_req && (flush_q != {COUNT_W{1'b1}}))
        flush_q <= flush_q + 1'b1;
    end
  end

  always_comb begin
    valid_count = '0;
    for (int i = 0; i < NUM_STAGES; i++)
      valid_count = valid_count + VC_W'(valid_q[i]);
  end

  assign out_data     = data_q;
  assign out_valid    = valid_q;
  assign stall_cycles = stall_q;
  assign flush_events = flush_q;

endmodule
